paver_kbd_arbiter: RTL and testbench

Keystroke scheduler between the Paver PS/2 keyboard decoder and two consumers: the CPU key port (requester 0) and the debug monitor (requester 1). It polls the decoder's one-character key register, drains it with a single-cycle `pickup` pulse and buffers the keys in a small FIFO. Keys are delivered only to the requester that currently owns keyboard focus, so the decoder is never read by two agents at once and keys are not lost between polls.

---
 rtl/paver_kbd_arbiter.sv | 129 ++++++++++++
 tb/tb_paver_kbd_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/paver_kbd_arbiter.sv
// Keystroke scheduler: drains the PS/2 decoder key register into a FIFO and serves only the focus owner.
// Optional macro PAVER_KBD_FOCUS_HOTKEY_EN: Ctrl+F12 toggles focus instead of the focus_sel input.
module paver_kbd_arbiter #(
  parameter int DEPTH_LOG2 = 3
) (
  input  logic                  coreclk,
  input  logic                  reset,
  input  logic [7:0]            ps2key,
  input  logic                  ctrl_pressed,
  output logic                  pickup,
  input  logic                  focus_sel,
  input  logic                  rd0,
  input  logic                  rd1,
  output logic [7:0]            key0,
  output logic [7:0]            key1,
  output logic                  valid0,
  output logic                  valid1,
  output logic                  owner,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overflow
);

  localparam int DATA_W = 8;
  localparam int DEPTH  = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DATA_W-1:0]   HOTKEY   = 8'd28;

  typedef enum logic [1:0] {IDLE, PICK, SETTLE} state_t;

  state_t                  state, state_nxt;
  logic                    pickup_nxt;
  logic                    cap_en;
  logic [DATA_W-1:0]       cap_key;
  logic [DATA_W-1:0]       mem [DEPTH];
  logic [DEPTH_LOG2-1:0]   wr_ptr, rd_ptr;
  logic                    hotkey, flush, owner_nxt;
  logic                    empty, full, push, pop, do_wr, do_pop, drop;
  logic [DATA_W-1:0]       head;

  always_comb begin
    state_nxt  = state;
    pickup_nxt = 1'b0;
    cap_en     = 1'b0;
    case (state)
      IDLE: begin
        if (ps2key != '0) begin
          cap_en     = 1'b1;
          pickup_nxt = 1'b1;
          state_nxt  = PICK;
        end
      end
      PICK:    state_nxt = SETTLE;
      // SETTLE lets the decoder show its cleared register before we poll again
      SETTLE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge coreclk) begin
    if (!reset) begin
      state  <= IDLE;
      pickup <= 1'b0;
    end else begin
      state  <= state_nxt;
      pickup <= pickup_nxt;
    end
  end

  always_ff @(posedge coreclk) begin
    if (cap_en) cap_key <= ps2key;
  end

`ifdef PAVER_KBD_FOCUS_HOTKEY_EN
  logic unused_focus;
  assign unused_focus = focus_sel;
  assign hotkey    = (state == PICK) && ctrl_pressed && (cap_key == HOTKEY);
  assign owner_nxt = owner ^ hotkey;
  assign flush     = hotkey;
`else
  logic unused_ctrl;
  assign unused_ctrl = ctrl_pressed;
  assign hotkey    = 1'b0;
  assign owner_nxt = focus_sel;
  assign flush     = (focus_sel != owner);
`endif

  assign empty  = (count == '0);
  assign full   = (count == FULL_CNT);
  assign valid0 = !empty && !owner;
  assign valid1 = !empty && owner;
  assign pop    = (owner ? rd1 : rd0) && !empty;
  assign push   = (state == PICK) && !hotkey;
  // A flush wins over both a same-cycle pop and a same-cycle write
  assign do_pop = pop && !flush;
  assign do_wr  = push && (!full || pop) && !flush;
  assign drop   = push && full && !pop && !flush;

  always_ff @(posedge coreclk) begin
    if (!reset) begin
      owner    <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      owner <= owner_nxt;
      if (drop) overflow <= 1'b1;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (do_wr)  wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
        if (do_pop) rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
        if (do_wr && !do_pop)      count <= count + (DEPTH_LOG2+1)'(1);
        else if (!do_wr && do_pop) count <= count - (DEPTH_LOG2+1)'(1);
      end
    end
  end

  always_ff @(posedge coreclk) begin
    if (do_wr) mem[wr_ptr] <= cap_key;
  end

  assign head = mem[rd_ptr];
  assign key0 = valid0 ? head : '0;
  assign key1 = valid1 ? head : '0;

endmodule

// File: tb/tb_paver_kbd_arbiter.sv
// Scoreboard bench for paver_kbd_arbiter: stimulus queues expectations, a negedge monitor compares.
module tb_paver_kbd_arbiter;

  localparam int DL2 = 3;

  localparam int S_COUNT = 0, S_OVF = 1, S_OWNER = 2, S_VALID0 = 3, S_VALID1 = 4,
                 S_KEY0 = 5, S_KEY1 = 6, S_PICKUP = 7, S_PCNT = 8, S_QLEFT = 9;

  typedef struct {
    int    sig;
    int    exp;
    string name;
  } chk_t;

  logic           coreclk = 1'b0;
  logic           reset, ctrl_pressed, focus_sel, rd0, rd1;
  logic [7:0]     ps2key;
  logic           pickup, valid0, valid1, owner, overflow;
  logic [7:0]     key0, key1;
  logic [DL2:0]   count;

  logic [7:0]     exp_q[$];
  chk_t           chk_q[$];
  int             vectors = 0;
  int             miscompares = 0;
  int             pickup_cnt = 0;

  paver_kbd_arbiter #(.DEPTH_LOG2(DL2)) dut (
    .coreclk(coreclk), .reset(reset), .ps2key(ps2key), .ctrl_pressed(ctrl_pressed),
    .pickup(pickup), .focus_sel(focus_sel), .rd0(rd0), .rd1(rd1),
    .key0(key0), .key1(key1), .valid0(valid0), .valid1(valid1),
    .owner(owner), .count(count), .overflow(overflow)
  );

  always #5 coreclk = ~coreclk;

  function automatic int sample(input int sig);
    case (sig)
      S_COUNT:  return int'(count);
      S_OVF:    return int'(overflow);
      S_OWNER:  return int'(owner);
      S_VALID0: return int'(valid0);
      S_VALID1: return int'(valid1);
      S_KEY0:   return int'(key0);
      S_KEY1:   return int'(key1);
      S_PICKUP: return int'(pickup);
      S_PCNT:   return pickup_cnt;
      S_QLEFT:  return exp_q.size();
      default:  return -1;
    endcase
  endfunction

  // Monitor: key pops against the scoreboard, then any queued signal expectations
  initial begin
    logic [7:0] e;
    chk_t c;
    int act;
    forever begin
      @(negedge coreclk);
      if (pickup) pickup_cnt++;
      if (rd0 && valid0) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL key0_pop: got %02h, expected no key", key0);
        end else begin
          e = exp_q.pop_front();
          if (key0 !== e) begin
            miscompares++;
            $display("FAIL key0_pop: got %02h, expected %02h", key0, e);
          end
        end
      end
      if (rd1 && valid1) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL key1_pop: got %02h, expected no key", key1);
        end else begin
          e = exp_q.pop_front();
          if (key1 !== e) begin
            miscompares++;
            $display("FAIL key1_pop: got %02h, expected %02h", key1, e);
          end
        end
      end
      while (chk_q.size() > 0) begin
        c = chk_q.pop_front();
        act = sample(c.sig);
        vectors++;
        if (act != c.exp) begin
          miscompares++;
          $display("FAIL %s: got %0h, expected %0h", c.name, act, c.exp);
        end
      end
    end
  end

  task automatic tick();
    @(posedge coreclk);
    #1;
  endtask

  task automatic expect_sig(input int sig, input int exp, input string name);
    chk_t c;
    c.sig = sig;
    c.exp = exp;
    c.name = name;
    chk_q.push_back(c);
  endtask

  // Decoder model: hold the key until pickup, clear it after E1
  task automatic send_key(input logic [7:0] k, input bit pop0);
    int n;
    n = 0;
    ps2key = k;
    while (!pickup && n < 8) begin
      tick();
      n++;
    end
    if (!pickup) begin
      expect_sig(S_PICKUP, 1, "pickup_timeout");
      ps2key = 8'h00;
      tick();
      return;
    end
    if (pop0) rd0 = 1'b1;
    tick();
    if (pop0) rd0 = 1'b0;
    ps2key = 8'h00;
    tick();
  endtask

  task automatic drain0(input int n);
    rd0 = 1'b1;
    repeat (n) tick();
    rd0 = 1'b0;
  endtask

  task automatic drain1(input int n);
    rd1 = 1'b1;
    repeat (n) tick();
    rd1 = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int base;
    reset = 1'b0; ps2key = 8'h61; ctrl_pressed = 1'b0; focus_sel = 1'b0;
    rd0 = 1'b0; rd1 = 1'b0;
    repeat (3) tick();
    expect_sig(S_PICKUP, 0, "rst_pickup");
    expect_sig(S_COUNT,  0, "rst_count");
    expect_sig(S_OVF,    0, "rst_overflow");
    expect_sig(S_OWNER,  0, "rst_owner");
    expect_sig(S_KEY0,   0, "rst_key0");
    expect_sig(S_KEY1,   0, "rst_key1");
    expect_sig(S_VALID0, 0, "rst_valid0");
    expect_sig(S_VALID1, 0, "rst_valid1");
    tick();

    // First key after reset release
    base = pickup_cnt;
    reset = 1'b1;
    exp_q.push_back(8'h61);
    send_key(8'h61, 1'b0);
    expect_sig(S_VALID0, 1, "first_valid0");
    expect_sig(S_KEY0, 8'h61, "first_key0");
    expect_sig(S_COUNT, 1, "first_count");
    expect_sig(S_VALID1, 0, "first_valid1");
    expect_sig(S_KEY1, 0, "first_key1");
    repeat (3) tick();
    expect_sig(S_PCNT, base + 1, "first_pickup_pulses");
    drain0(1);
    expect_sig(S_VALID0, 0, "first_drained_valid0");
    expect_sig(S_COUNT, 0, "first_drained_count");
    tick();

    // Overflow: nine keys into eight slots
    for (int k = 8'h31; k <= 8'h39; k++) begin
      if (k <= 8'h38) exp_q.push_back(8'(k));
      send_key(8'(k), 1'b0);
      if (k == 8'h38) begin
        expect_sig(S_COUNT, 8, "ovf_full_count");
        expect_sig(S_OVF, 0, "ovf_before_drop");
      end
    end
    expect_sig(S_COUNT, 8, "ovf_count");
    expect_sig(S_OVF, 1, "ovf_flag");
    drain0(8);
    expect_sig(S_VALID0, 0, "ovf_drained_valid0");
    expect_sig(S_COUNT, 0, "ovf_drained_count");
    expect_sig(S_OVF, 1, "ovf_sticky");
    reset = 1'b0;
    repeat (2) tick();
    reset = 1'b1;
    expect_sig(S_OVF, 0, "ovf_cleared_by_reset");
    tick();

    // Full FIFO with a pop in the push cycle
    for (int k = 8'h31; k <= 8'h38; k++) begin
      exp_q.push_back(8'(k));
      send_key(8'(k), 1'b0);
    end
    expect_sig(S_COUNT, 8, "fullpop_pre_count");
    exp_q.push_back(8'h39);
    send_key(8'h39, 1'b1);
    expect_sig(S_COUNT, 8, "fullpop_count");
    expect_sig(S_OVF, 0, "fullpop_overflow");
    drain0(8);
    expect_sig(S_VALID0, 0, "fullpop_drained_valid0");
    tick();

`ifdef PAVER_KBD_FOCUS_HOTKEY_EN
    send_key(8'h41, 1'b0);
    expect_sig(S_COUNT, 1, "hk_pre_count");
    ctrl_pressed = 1'b1;
    send_key(8'd28, 1'b0);
    ctrl_pressed = 1'b0;
    expect_sig(S_OWNER, 1, "hk_owner");
    expect_sig(S_COUNT, 0, "hk_flush_count");
    exp_q.push_back(8'h42);
    send_key(8'h42, 1'b0);
    expect_sig(S_KEY1, 8'h42, "hk_key1");
    expect_sig(S_VALID1, 1, "hk_valid1");
    expect_sig(S_VALID0, 0, "hk_valid0");
    expect_sig(S_KEY0, 0, "hk_key0");
    drain1(1);
    focus_sel = 1'b1;
    tick();
    focus_sel = 1'b0;
    tick();
    expect_sig(S_OWNER, 1, "hk_focus_sel_ignored");
    ctrl_pressed = 1'b1;
    send_key(8'd28, 1'b0);
    ctrl_pressed = 1'b0;
    expect_sig(S_OWNER, 0, "hk_owner_back");
    tick();
`else
    exp_q.push_back(8'd28);
    ctrl_pressed = 1'b1;
    send_key(8'd28, 1'b0);
    ctrl_pressed = 1'b0;
    expect_sig(S_COUNT, 1, "fs_key28_count");
    expect_sig(S_OWNER, 0, "fs_key28_owner");
    drain0(1);
    send_key(8'h71, 1'b0);
    send_key(8'h72, 1'b0);
    expect_sig(S_COUNT, 2, "fs_pre_count");
    focus_sel = 1'b1;
    expect_sig(S_OWNER, 0, "fs_owner_before_edge");
    tick();
    expect_sig(S_OWNER, 1, "fs_owner");
    expect_sig(S_COUNT, 0, "fs_flush_count");
    expect_sig(S_VALID0, 0, "fs_valid0");
    expect_sig(S_KEY0, 0, "fs_key0");
    rd0 = 1'b1;
    exp_q.push_back(8'h73);
    exp_q.push_back(8'h74);
    send_key(8'h73, 1'b0);
    send_key(8'h74, 1'b0);
    expect_sig(S_COUNT, 2, "fs_rd0_ignored_count");
    expect_sig(S_KEY1, 8'h73, "fs_key1");
    expect_sig(S_KEY0, 0, "fs_nonowner_key0");
    rd0 = 1'b0;
    drain1(2);
    expect_sig(S_VALID1, 0, "fs_drained_valid1");
    focus_sel = 1'b0;
    tick();
    expect_sig(S_OWNER, 0, "fs_owner_back");
    tick();
`endif

    // Reset during PICK with the key still held by the decoder
    ps2key = 8'h55;
    for (int n = 0; n < 8 && !pickup; n++) tick();
    expect_sig(S_PICKUP, 1, "rpick_pickup_seen");
    reset = 1'b0;
    tick();
    tick();
    expect_sig(S_COUNT, 0, "rpick_count");
    expect_sig(S_PICKUP, 0, "rpick_pickup");
    tick();
    base = pickup_cnt;
    reset = 1'b1;
    exp_q.push_back(8'h55);
    send_key(8'h55, 1'b0);
    repeat (4) tick();
    expect_sig(S_COUNT, 1, "rpick_recapture_count");
    expect_sig(S_KEY0, 8'h55, "rpick_key0");
    expect_sig(S_PCNT, base + 1, "rpick_single_pickup");
    drain0(1);
    expect_sig(S_QLEFT, 0, "scoreboard_empty");
    repeat (2) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
